clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 The block SHALL take parameter NUM_CH, default 2, giving the number of independent divider channels (1..16).
REQ-002 The block SHALL take parameter CNT_W, default 16, giving the divisor and counter width in bits (2..32).
REQ-003 The block SHALL define local CH_W = max(1, clog2(NUM_CH)).
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: a synchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: global run; while low, all channels freeze.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: a divisor update is offered.
REQ-008 The block SHALL have port cfg_ready, output, 1 bit: the block can accept the offered update.
REQ-009 The block SHALL have port cfg_ch, input, CH_W bits: the target channel of the update.
REQ-010 The block SHALL have port cfg_div, input, CNT_W bits: the new divisor D; D=0 means stop.
REQ-011 The block SHALL have port ce_out, output, NUM_CH bits: a one-cycle clock-enable pulse per channel.
REQ-012 The block SHALL have port div_out, output, NUM_CH bits: a 50%-duty square wave per channel, with period 2*D cycles.
REQ-013 The block SHALL have port active, output, NUM_CH bits: the channel's current divisor is nonzero.

Function
REQ-014 Each channel SHALL hold registers div (current divisor), cnt (0..div-1), pend (flag) and pdiv (pending divisor).
REQ-015 cfg_ready SHALL equal ~pend[cfg_ch] when cfg_ch < NUM_CH, SHALL be 1 when cfg_ch >= NUM_CH, and SHALL be forced 0 while reset is high.
REQ-016 A transfer SHALL occur on a rising edge where cfg_valid && cfg_ready; it SHALL set pend <= 1 and pdiv <= cfg_div for channel cfg_ch.
REQ-017 A transfer to cfg_ch >= NUM_CH SHALL be accepted and discarded.
REQ-018 When enable = 1, div != 0 and cnt == div-1, the next edge SHALL set cnt <= 0, ce_out[i] <= 1 and div_out[i] <= ~div_out[i].
REQ-019 When enable = 1, div != 0 and cnt != div-1, the next edge SHALL set cnt <= cnt+1 and ce_out[i] <= 0.
REQ-020 A pending update SHALL apply only at a period boundary or while the channel is idle, never mid-period.
REQ-021 A period boundary SHALL be the cycle where enable = 1, pend = 1 and cnt == div-1.
REQ-022 The channel SHALL be idle when div == 0; a pending update SHALL apply on the first enabled cycle in which pend = 1 and div == 0.
REQ-023 On apply, the channel SHALL set div <= pdiv, cnt <= 0 and pend <= 0.
REQ-024 If an update applies at a period boundary, that same edge SHALL still issue the ce_out pulse and div_out toggle for the ending period.
REQ-025 If the applied pdiv == 0, the channel SHALL also set div_out[i] <= 0, and ce_out[i] SHALL stay 0 thereafter.
REQ-026 An idle channel SHALL hold cnt = 0, ce_out[i] = 0 and div_out[i] = 0.
REQ-027 With D = 1, ce_out[i] SHALL stay high continuously and div_out[i] SHALL toggle every cycle (divide by 2).
REQ-028 While enable = 0, cnt, div, div_out and pend application SHALL freeze, ce_out SHALL be 0 on the next edge, and cfg transfers SHALL still be accepted.
REQ-029 Latency SHALL be: transfer at edge t to an idle channel -> apply at edge t+1 -> first ce_out high during cycle t+D+2, with no enable gaps.
REQ-030 A transfer to a channel in the same cycle its pending update applies SHALL NOT occur, since cfg_ready reflects the registered pend = 1; the next transfer is accepted one cycle later.
REQ-031 Channels SHALL be fully independent; simultaneous boundaries on several channels SHALL all be honoured in the same cycle.
REQ-032 active[i] SHALL be (div[i] != 0), taken directly from the register.
REQ-033 All outputs except cfg_ready SHALL be registered, with no combinational path from the cfg inputs to ce_out, div_out or active.

Reset
REQ-034 While reset is high at an edge, every channel SHALL clear div, cnt, pend, pdiv, ce_out, div_out and active to 0.
REQ-035 Reset asserted mid-period or with an update pending SHALL discard all state on that edge, with no boundary wait.
REQ-036 In the first cycle after reset deasserts, cfg_ready SHALL be 1 and all channels SHALL be idle.

Verification
REQ-037 Scenario: enable = 1; transfer ch0 D=3 at edge 0 -> ce_out[0] high in cycles 5, 8, 11; div_out[0] rises at 5 and falls at 8.
REQ-038 Scenario: ch0 running with D=4; transfer D=2 mid-period -> the current 4-cycle period completes, then pulses follow every 2 cycles; cfg_ready for ch0 is low until the apply.
REQ-039 Scenario: ch1 running with D=5; transfer D=0 -> at the next boundary a final ce_out pulse occurs, then div_out[1] = 0, active[1] = 0, and no further pulses.
REQ-040 Scenario: ch0 D=2 and ch1 D=3 running together; drop enable for 4 cycles -> both counters and div_out hold, no pulses occur, and the phase resumes unchanged afterwards.
REQ-041 Scenario: D=1 on ch0 -> ce_out[0] is constantly high and div_out[0] toggles every cycle.
REQ-042 Scenario: assert reset for 1 cycle mid-period with an update pending -> all outputs are 0 next cycle, cfg_ready = 1 after release, and the pending update is lost.

Source files
------------

// File: rtl/clk_div_bank.sv
// clk_div_bank: bank of NUM_CH independent clock dividers sharing one clock.
//
// Each channel divides clk_in by 2*D, where D is a per-channel divisor loaded
// through a valid/ready config port. New divisors are held pending and only
// take effect at a period boundary (or immediately if the channel is idle), so
// a running output never produces a truncated period.
//
// Ports:
//   clk_in     in   single clock, all state on rising edge
//   reset      in   synchronous, active-high reset
//   enable     in   global run; low freezes every channel
//   cfg_valid  in   divisor update offered
//   cfg_ready  out  update can be accepted (combinational from pend)
//   cfg_ch     in   target channel; out-of-range channels are accepted and dropped
//   cfg_div    in   new divisor D; 0 stops the channel
//   ce_out     out  one-cycle clock-enable pulse per channel, once per D cycles
//   div_out    out  50%-duty square wave per channel, period 2*D
//   active     out  channel's current divisor is nonzero
module clk_div_bank #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] active
);

    logic [CNT_W-1:0]  r_div  [NUM_CH];
    logic [CNT_W-1:0]  r_cnt  [NUM_CH];
    logic [CNT_W-1:0]  r_pdiv [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_ce;
    logic [NUM_CH-1:0] r_dout;

    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_last;
    logic              w_pend_sel;
    logic              w_xfer;

    // Channel decode. An out-of-range cfg_ch matches nothing, so w_pend_sel
    // stays 0 and the update is accepted but lands nowhere.
    always_comb begin
        w_pend_sel = 1'b0;
        w_hit      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_pend_sel = r_pend[i];
                w_hit[i]   = 1'b1;
            end
        end
    end

    assign cfg_ready = ~reset & ~w_pend_sel;
    assign w_xfer    = cfg_valid & cfg_ready;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_last[i] = (r_cnt[i] == r_div[i] - CNT_W'(1));
            active[i] = (r_div[i] != '0);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]  <= '0;
                r_cnt[i]  <= '0;
                r_pdiv[i] <= '0;
            end
            r_pend <= '0;
            r_ce   <= '0;
            r_dout <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (enable) begin
                    if (r_div[i] == '0) begin
                        // Idle: outputs parked low, pending divisor applies at once.
                        r_cnt[i]  <= '0;
                        r_ce[i]   <= 1'b0;
                        r_dout[i] <= 1'b0;
                        if (r_pend[i]) begin
                            r_div[i]  <= r_pdiv[i];
                            r_pend[i] <= 1'b0;
                        end
                    end else if (w_last[i]) begin
                        // Period boundary: the ending period still pulses and toggles.
                        r_cnt[i]  <= '0;
                        r_ce[i]   <= 1'b1;
                        r_dout[i] <= ~r_dout[i];
                        if (r_pend[i]) begin
                            r_div[i]  <= r_pdiv[i];
                            r_pend[i] <= 1'b0;
                            if (r_pdiv[i] == '0) begin
                                r_dout[i] <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                        r_ce[i]  <= 1'b0;
                    end
                end else begin
                    r_ce[i] <= 1'b0;
                end

                // cfg_ready requires pend=0, so this never collides with an apply.
                if (w_xfer && w_hit[i]) begin
                    r_pend[i] <= 1'b1;
                    r_pdiv[i] <= cfg_div;
                end
            end
        end
    end

    assign ce_out  = r_ce;
    assign div_out = r_dout;

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: self-checking bench for clk_div_bank (3 channels, 8-bit divisors).
// A behavioural model counts down the enabled cycles left in each channel's
// period and predicts every output; scenario tasks also check fixed timings.
module tb_clk_div_bank;

    localparam int NCH = 3;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic [2:0] ce_out;
    logic [2:0] div_out;
    logic [2:0] active;

    int errors = 0;
    int checks = 0;

    clk_div_bank #(
        .NUM_CH(NCH),
        .CNT_W (8)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .enable   (enable),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .ce_out   (ce_out),
        .div_out  (div_out),
        .active   (active)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    int m_div  [NCH];
    int m_left [NCH];   // enabled edges remaining until this period's pulse
    int m_pdiv [NCH];
    bit m_pend [NCH];
    bit m_ce   [NCH];
    bit m_lvl  [NCH];

    function automatic bit model_ready();
        int c;
        c = int'(cfg_ch);
        if (reset) return 1'b0;
        if (c < NCH && m_pend[c]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [2:0] a, b, c;
        for (int i = 0; i < NCH; i++) begin
            a[i] = m_ce[i];
            b[i] = m_lvl[i];
            c[i] = (m_div[i] != 0);
        end
        return {a, b, c, model_ready()};
    endfunction

    task automatic model_update();
        bit xfer;
        int c;
        xfer = cfg_valid && model_ready();
        c    = int'(cfg_ch);
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_div[i] = 0; m_left[i] = 0; m_pdiv[i] = 0;
                m_pend[i] = 0; m_ce[i] = 0; m_lvl[i] = 0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!enable) begin
                    m_ce[i] = 0;
                end else if (m_div[i] == 0) begin
                    m_ce[i]  = 0;
                    m_lvl[i] = 0;
                    if (m_pend[i]) begin
                        m_div[i] = m_pdiv[i]; m_left[i] = m_pdiv[i]; m_pend[i] = 0;
                    end
                end else begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        m_ce[i]   = 1;
                        m_lvl[i]  = !m_lvl[i];
                        m_left[i] = m_div[i];
                        if (m_pend[i]) begin
                            m_div[i] = m_pdiv[i]; m_left[i] = m_pdiv[i]; m_pend[i] = 0;
                            if (m_div[i] == 0) m_lvl[i] = 0;
                        end
                    end else begin
                        m_ce[i] = 0;
                    end
                end
            end
            if (xfer && c < NCH) begin
                m_pend[c] = 1;
                m_pdiv[c] = int'(cfg_div);
            end
        end
    endtask

    initial forever begin
        @(posedge clk_in);
        model_update();
    end

    // Drive one cycle of inputs on the falling edge, then settle.
    task automatic step(input bit r, input bit en, input bit v, input int ch, input int d);
        @(negedge clk_in);
        reset     = r;
        enable    = en;
        cfg_valid = v;
        cfg_ch    = 2'(ch);
        cfg_div   = 8'(d);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checks++;
        if ({ce_out, div_out, active, cfg_ready} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", {ce_out, div_out, active, cfg_ready}, 10'd0);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (cfg_ready !== 1'b1 || active !== 3'b000) begin
            errors++;
            $display("FAIL reset_release got ready=%b active=%b exp ready=1 active=000",
                     cfg_ready, active);
        end
    endtask

    task automatic test_latency();
        bit ce_exp, lv_exp;
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 3);    // transfer at edge 0
        for (int cyc = 1; cyc <= 12; cyc++) begin
            step(0, 1, 0, 0, 0);
            ce_exp = (cyc == 5 || cyc == 8 || cyc == 11);
            lv_exp = (cyc >= 5 && cyc <= 7) || (cyc >= 11);
            checks++;
            if (ce_out[0] !== ce_exp || div_out[0] !== lv_exp) begin
                errors++;
                $display("FAIL latency cyc=%0d got ce=%b div=%b exp ce=%b div=%b",
                         cyc, ce_out[0], div_out[0], ce_exp, lv_exp);
            end
            checks++;
            if ({ce_out, div_out, active, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL latency_model cyc=%0d got=%b exp=%b", cyc,
                         {ce_out, div_out, active, cfg_ready}, exp_vec());
            end
        end
    endtask

    task automatic test_mid_update();
        int pulses = 0;
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 4);
        for (int k = 0; k < 9; k++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 2);
        for (int j = 1; j <= 14; j++) begin
            step(0, 1, 0, 0, 0);
            if (j == 1) begin
                checks++;
                if (cfg_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL mid_update_ready got=%b exp=0", cfg_ready);
                end
            end
            if (j >= 7) pulses += int'(ce_out[0]);
            checks++;
            if ({ce_out, div_out, active, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL mid_update_model j=%0d got=%b exp=%b", j,
                         {ce_out, div_out, active, cfg_ready}, exp_vec());
            end
        end
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL mid_update_rate got=%0d pulses exp=4", pulses);
        end
    endtask

    task automatic test_stop();
        int pulses = 0;
        step(1, 1, 0, 1, 0);
        step(0, 1, 1, 1, 5);
        for (int k = 0; k < 12; k++) step(0, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0);
        for (int j = 1; j <= 8; j++) begin
            step(0, 1, 0, 1, 0);
            pulses += int'(ce_out[1]);
            checks++;
            if ({ce_out, div_out, active, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL stop_model j=%0d got=%b exp=%b", j,
                         {ce_out, div_out, active, cfg_ready}, exp_vec());
            end
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL stop_final_pulse got=%0d exp=1", pulses);
        end
        for (int j = 0; j < 12; j++) begin
            step(0, 1, 0, 1, 0);
            checks++;
            if (ce_out[1] !== 1'b0 || div_out[1] !== 1'b0 || active[1] !== 1'b0) begin
                errors++;
                $display("FAIL stop_idle got ce=%b div=%b act=%b exp 0 0 0",
                         ce_out[1], div_out[1], active[1]);
            end
        end
    endtask

    task automatic test_enable_freeze();
        logic [2:0] held;
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 2);
        step(0, 1, 1, 1, 3);
        for (int k = 0; k < 10; k++) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        held = div_out;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, (k == 1), 2, 1);
            checks++;
            if (ce_out !== 3'b000 || div_out !== held) begin
                errors++;
                $display("FAIL freeze k=%0d got ce=%b div=%b exp ce=000 div=%b",
                         k, ce_out, div_out, held);
            end
        end
        for (int k = 0; k < 12; k++) begin
            step(0, 1, 0, 0, 0);
            checks++;
            if ({ce_out, div_out, active, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL freeze_resume k=%0d got=%b exp=%b", k,
                         {ce_out, div_out, active, cfg_ready}, exp_vec());
            end
        end
    endtask

    task automatic test_div1();
        logic prev;
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        prev = div_out[0];
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, 0, 0);
            checks++;
            if (ce_out[0] !== 1'b1 || div_out[0] !== ~prev) begin
                errors++;
                $display("FAIL div1 k=%0d got ce=%b div=%b exp ce=1 div=%b",
                         k, ce_out[0], div_out[0], ~prev);
            end
            prev = div_out[0];
        end
    endtask

    task automatic test_reset_mid();
        step(1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 4);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 6);
        step(1, 1, 0, 0, 0);
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ready_in_reset got=%b exp=0", cfg_ready);
        end
        step(0, 1, 0, 0, 0);
        checks++;
        if ({ce_out, div_out, active, cfg_ready} !== 10'b000_000_000_1) begin
            errors++;
            $display("FAIL reset_mid_clear got=%b exp=%b",
                     {ce_out, div_out, active, cfg_ready}, 10'b000_000_000_1);
        end
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 0, 0, 0);
            checks++;
            if (active !== 3'b000 || ce_out !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_lost k=%0d got act=%b ce=%b exp 000 000",
                         k, active, ce_out);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5)));
            checks++;
            if ({ce_out, div_out, active, cfg_ready} !== exp_vec()) begin
                errors++;
                $display("FAIL random k=%0d got=%b exp=%b", k,
                         {ce_out, div_out, active, cfg_ready}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_mid_update();
        test_stop();
        test_enable_freeze();
        test_div1();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
